ring_token_arbiter: RTL and testbench
=====================================

Name: ring_token_arbiter

Overview:
Round-robin arbiter that shares a single resource among N requesters. A rotating one-hot ring pointer (ring counter) sets the search start. The block issues a registered one-hot grant, holds it for a bounded burst, then passes the token on. It sits between requester blocks and the shared datapath, and drives that datapath's select.

Parameters:
N, 4, number of requesters; legal values N >= 2
MAX_HOLD, 8, maximum consecutive cycles one owner may hold the grant; legal values MAX_HOLD >= 1
ID_W, $clog2(N), width of gnt_id

Ports:
clk  in  1  system clock; all state updates on rising edge
rst  in  1  synchronous reset, active-low; sampled on clk rising edge
req  in  N  request vector; req[i]=1 means requester i wants the resource
gnt  out  N  one-hot grant, registered; all zeros when no grant
gnt_valid  out  1  1 when gnt is non-zero
gnt_id  out  ID_W  binary index of the granted requester; 0 when gnt_valid=0
ptr  out  N  one-hot ring pointer marking where the next search starts

Behaviour:
- Reset (rst=0 at a clk edge): gnt=0, gnt_valid=0, gnt_id=0, ptr=1 (bit0), hold_cnt=0, state=IDLE. Reset overrides all other activity, including a grant in progress.
- The design has exactly two states: IDLE and GRANT.
- Winner search:
  - Scan starts at the ptr bit and moves upward, wrapping from N-1 to 0.
  - The first set req bit wins.
  - The search is combinational; the result is registered.
- IDLE state:
  - If req != 0 at an edge, gnt <= winner one-hot, hold_cnt <= 1, and the state moves to GRANT.
  - Latency is 1 cycle from req sampled to gnt visible.
  - If req = 0, the block stays in IDLE with gnt = 0.
- GRANT state, owner o:
  - Continue condition: req[o]=1 and hold_cnt < MAX_HOLD. Then gnt is unchanged and hold_cnt increments.
  - Release condition: req[o]=0, or hold_cnt == MAX_HOLD. On release, all of the following happen at the same edge:
    - ptr <= rotate_left(gnt), i.e. bit o+1, wrapping N-1 to 0.
    - The new winner is searched from the new ptr value using the current req.
    - If a winner exists, gnt <= winner and hold_cnt <= 1 with no idle bubble; the state stays GRANT.
    - If no winner exists, gnt <= 0, hold_cnt <= 0, and the state moves to IDLE.
  - The old owner can win at release only if it is the sole requester. In that case it is re-granted back-to-back with a fresh hold_cnt.
- Hold rules:
  - Each owner holds the grant for at most MAX_HOLD consecutive cycles before a release edge.
  - With MAX_HOLD=1, the block is a pure per-cycle round robin.
- ptr behaviour:
  - ptr changes only on release edges and on reset.
  - ptr stays one-hot in every cycle.
- gnt behaviour:
  - gnt is always zero or one-hot.
  - gnt_id and gnt_valid are registered together with gnt; there is no combinational path from req to any output.
- req changes:
  - Requests from non-owners that rise or fall during a grant have no effect until the next release edge.
  - If the owner deasserts req, gnt still stays asserted for the cycle in which req=0 is first sampled. It moves at that edge.
- hold_cnt is internal and must be wide enough to hold MAX_HOLD.

Test Plan:
1. Reset: hold rst=0 for 5 cycles with req=1111 (N=4, MAX_HOLD=8) -> gnt=0000, gnt_valid=0, gnt_id=0, ptr=0001 throughout. First grant gnt=0001 appears 1 cycle after rst=1.
2. All requesting: req=1111 held for 40 cycles -> gnt sequence 0001 x8, 0010 x8, 0100 x8, 1000 x8, 0001 x8. gnt_id steps 0,1,2,3,0. ptr reads 0010, 0100, 1000, 0001 after each release. There are no gnt=0 cycles.
3. Sole requester: req=0100 held for 20 cycles -> gnt=0100 continuous with no bubble at the expiry after 8 cycles. ptr goes 0001 -> 1000 at the first expiry and 1000 -> 1000 at the second expiry.
4. Early drop: req=0011. Drop req[0] after it has been granted 3 cycles -> at the edge that samples req[0]=0, gnt <= 0010 and ptr <= 0010. req[1] then holds for up to 8 cycles.
5. Mid-grant reset: gnt=0010 with hold_cnt=4, then assert rst=0 for one edge -> gnt=0000 and ptr=0001 at that edge. After release with req=1111, the first grant is 0001.
6. Wrap and idle: from ptr=1000, req=1001. Owner 3 drops -> gnt <= 0001 and ptr <= 0001. Then req=0000 -> after the release edge, gnt=0000, gnt_valid=0, state IDLE, ptr=0010.

Source files
------------

// File: rtl/ring_token_arbiter.sv
// ring_token_arbiter: round-robin arbiter with a rotating one-hot ring pointer.
// Grants one requester at a time. The grant is held for at most MAX_HOLD
// cycles, then the token passes to the next requester.
// Ports:
//   clk       - system clock, rising edge
//   rst       - synchronous active-low reset
//   req       - request vector, one bit per requester
//   gnt       - registered one-hot grant (all zeros when idle)
//   gnt_valid - registered, 1 when gnt is non-zero
//   gnt_id    - registered binary index of the owner, 0 when idle
//   ptr       - registered one-hot search start pointer
module ring_token_arbiter #(
  parameter int unsigned N        = 4,
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned ID_W     = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  output logic [N-1:0]    gnt,
  output logic            gnt_valid,
  output logic [ID_W-1:0] gnt_id,
  output logic [N-1:0]    ptr
);

  localparam int unsigned HOLD_W = $clog2(MAX_HOLD + 1);

  typedef enum logic {IDLE, GRANT} state_e;

  state_e            state_q, state_d;
  logic [N-1:0]      gnt_q, gnt_d;
  logic [N-1:0]      ptr_q, ptr_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              gnt_valid_q, gnt_valid_d;
  logic [ID_W-1:0]   gnt_id_q, gnt_id_d;

  // First set request at or above the pointer bit, else the lowest set
  // request overall (the wrap-around part of the scan).
  function automatic logic [N-1:0] pick(input logic [N-1:0] r, input logic [N-1:0] p);
    logic [N-1:0] hi;
    hi = r & ~(p - N'(1));
    if (hi != '0) return hi & (~hi + N'(1));
    else          return r & (~r + N'(1));
  endfunction

  function automatic logic [ID_W-1:0] to_bin(input logic [N-1:0] oh);
    logic [ID_W-1:0] id;
    id = '0;
    for (int i = 0; i < N; i++) begin
      if (oh[i]) id = id | ID_W'(i);
    end
    return id;
  endfunction

  // Next-state and next-output logic
  always_comb begin
    logic [N-1:0] win;
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    win     = '0;
    unique case (state_q)
      IDLE: begin
        if (req != '0) begin
          gnt_d   = pick(req, ptr_q);
          hold_d  = HOLD_W'(1);
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (((req & gnt_q) != '0) && (hold_q < HOLD_W'(MAX_HOLD))) begin
          hold_d = hold_q + HOLD_W'(1);
        end else begin
          // Release: advance pointer past the owner and re-search in the same edge.
          ptr_d = {gnt_q[N-2:0], gnt_q[N-1]};
          win   = pick(req, ptr_d);
          if (win != '0) begin
            gnt_d  = win;
            hold_d = HOLD_W'(1);
          end else begin
            gnt_d   = '0;
            hold_d  = '0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    gnt_valid_d = (gnt_d != '0);
    gnt_id_d    = to_bin(gnt_d);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      ptr_q       <= N'(1);
      hold_q      <= '0;
      gnt_valid_q <= 1'b0;
      gnt_id_q    <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      ptr_q       <= ptr_d;
      hold_q      <= hold_d;
      gnt_valid_q <= gnt_valid_d;
      gnt_id_q    <= gnt_id_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_valid = gnt_valid_q;
  assign gnt_id    = gnt_id_q;
  assign ptr       = ptr_q;

endmodule

// File: tb/tb_ring_token_arbiter.sv
// Testbench for ring_token_arbiter: directed test-plan steps plus random
// requests and resets, compared against an integer-level reference model.
module tb_ring_token_arbiter;

  localparam int unsigned N        = 4;
  localparam int unsigned MAX_HOLD = 8;
  localparam int unsigned ID_W     = 2;

  logic            clk;
  logic            rst;
  logic [N-1:0]    req;
  logic [N-1:0]    gnt;
  logic            gnt_valid;
  logic [ID_W-1:0] gnt_id;
  logic [N-1:0]    ptr;

  int checks;
  int errors;

  // Reference model: owner index (-1 = none), cycles held, pointer index.
  int m_owner;
  int m_hold;
  int m_ptr;

  ring_token_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD), .ID_W(ID_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .gnt      (gnt),
    .gnt_valid(gnt_valid),
    .gnt_id   (gnt_id),
    .ptr      (ptr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int winner(input logic [N-1:0] r, input int start);
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (start + k) % N;
      if (((r >> idx) & N'(1)) != '0) return idx;
    end
    return -1;
  endfunction

  task automatic model_update(input logic [N-1:0] r, input logic rn);
    int w;
    if (!rn) begin
      m_owner = -1; m_hold = 0; m_ptr = 0;
    end else if (m_owner < 0) begin
      w = winner(r, m_ptr);
      if (w >= 0) begin m_owner = w; m_hold = 1; end
    end else if ((((r >> m_owner) & N'(1)) != '0) && (m_hold < MAX_HOLD)) begin
      m_hold = m_hold + 1;
    end else begin
      m_ptr = (m_owner + 1) % N;
      w = winner(r, m_ptr);
      if (w >= 0) begin m_owner = w; m_hold = 1; end
      else begin m_owner = -1; m_hold = 0; end
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [N-1:0]    eg;
    logic [ID_W-1:0] eid;
    logic            ev;
    logic [N-1:0]    ep;
    eg  = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
    eid = (m_owner >= 0) ? ID_W'(m_owner) : '0;
    ev  = (m_owner >= 0);
    ep  = N'(1) << m_ptr;
    checks++;
    assert (gnt === eg) else begin
      errors++; $error("FAIL %s gnt: got %b expected %b", tag, gnt, eg);
    end
    checks++;
    assert (gnt_id === eid) else begin
      errors++; $error("FAIL %s gnt_id: got %0d expected %0d", tag, gnt_id, eid);
    end
    checks++;
    assert (gnt_valid === ev) else begin
      errors++; $error("FAIL %s gnt_valid: got %b expected %b", tag, gnt_valid, ev);
    end
    checks++;
    assert (ptr === ep) else begin
      errors++; $error("FAIL %s ptr: got %b expected %b", tag, ptr, ep);
    end
  endtask

  // Apply inputs, advance one edge, update the model, check 1 time unit later.
  task automatic step(input logic [N-1:0] r, input logic rn, input string tag);
    req = r;
    rst = rn;
    @(posedge clk);
    model_update(r, rn);
    #1;
    check_outputs(tag);
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    m_owner = -1; m_hold = 0; m_ptr = 0;
    req = '0;
    rst = 1'b0;
    @(negedge clk);

    // 1: reset held with all requesting
    for (int i = 0; i < 5; i++) step(4'b1111, 1'b0, "reset");

    // 2: all requesting, 8-cycle bursts rotating through every requester
    for (int i = 0; i < 40; i++) begin
      step(4'b1111, 1'b1, "all_req");
      checks++;
      assert (gnt_id === ID_W'((i / 8) % 4)) else begin
        errors++; $error("FAIL all_req_seq gnt_id: got %0d expected %0d", gnt_id, (i / 8) % 4);
      end
      checks++;
      assert (ptr === (N'(1) << ((i / 8) % 4))) else begin
        errors++; $error("FAIL all_req_seq ptr: got %b expected %b", ptr, N'(1) << ((i / 8) % 4));
      end
    end

    // 3: sole requester re-granted without a bubble
    step(4'b1111, 1'b0, "rst3");
    for (int i = 0; i < 20; i++) begin
      step(4'b0100, 1'b1, "sole");
      checks++;
      assert (gnt === 4'b0100) else begin
        errors++; $error("FAIL sole_const gnt: got %b expected %b", gnt, 4'b0100);
      end
    end

    // 6: wrap and idle, starting from ptr=1000
    step(4'b1001, 1'b1, "wrap_a");
    step(4'b0001, 1'b1, "wrap_b");
    step(4'b0000, 1'b1, "wrap_idle");
    checks++;
    assert (ptr === 4'b0010 && gnt === 4'b0000) else begin
      errors++; $error("FAIL wrap_idle_const ptr/gnt: got %b/%b expected 0010/0000", ptr, gnt);
    end
    step(4'b0000, 1'b1, "idle_stay");

    // 4: early drop of requester 0 after 3 grant cycles
    step(4'b0000, 1'b0, "rst4");
    for (int i = 0; i < 3; i++) step(4'b0011, 1'b1, "early_hold");
    step(4'b0010, 1'b1, "early_drop");
    checks++;
    assert (gnt === 4'b0010 && ptr === 4'b0010) else begin
      errors++; $error("FAIL early_drop_const gnt/ptr: got %b/%b expected 0010/0010", gnt, ptr);
    end
    for (int i = 0; i < 9; i++) step(4'b0010, 1'b1, "early_next");

    // 5: reset in the middle of a burst
    step(4'b0000, 1'b0, "rst5");
    for (int i = 0; i < 4; i++) step(4'b0010, 1'b1, "mid_hold");
    step(4'b1111, 1'b0, "mid_rst");
    step(4'b1111, 1'b1, "mid_after");
    checks++;
    assert (gnt === 4'b0001) else begin
      errors++; $error("FAIL mid_after_const gnt: got %b expected 0001", gnt);
    end

    // Random requests with occasional resets
    for (int i = 0; i < 600; i++) begin
      logic [N-1:0] r;
      logic         rn;
      r  = N'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) r = N'(1) << $urandom_range(0, 3);
      rn = ($urandom_range(0, 79) != 0);
      step(r, rn, "random");
      checks++;
      assert ($onehot0(gnt) && $onehot(ptr)) else begin
        errors++; $error("FAIL random_onehot gnt/ptr: got %b/%b expected onehot0/onehot", gnt, ptr);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
